// File: rtl/dual_imm_decode_pkg.sv
// Shared definitions for the dual-lane immediate decoder.
//   - RV32I major-opcode constants (instr[6:2])
//   - imm_lane_t : per-lane decode result carried through the output buffer
//   - buf_state_e: occupancy of the 2-entry main/skid output buffer
package dual_imm_decode_pkg;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // 'type' is a reserved word, hence ext_type (0 = signed, 1 = unsigned).
  typedef struct packed {
    logic [31:0] imm_raw;
    logic [4:0]  op_code;
    logic        en;
    logic        ext_type;
    logic        lane_valid;
    logic        illegal;
  } imm_lane_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/dual_imm_decode_lane_format.sv
// imm_lane_format: purely combinational single-lane immediate formatter.
// Ports:
//   i_instr      - 32-bit RV32I instruction word
//   i_lane_valid - lane carries an instruction
//   o_lane       - formatted immediate, opcode, extender controls, illegal flag
module imm_lane_format
  import dual_imm_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic        i_lane_valid,
  output imm_lane_t   o_lane
);

  logic [4:0]  w_opc;
  logic        w_known;
  logic        w_len_ok;
  logic        w_en;
  logic [31:0] w_imm;

  assign w_opc    = i_instr[6:2];
  assign w_len_ok = (i_instr[1:0] == 2'b11);

  // Immediates whose extension happens downstream are zero-padded; STORE,
  // JAL and JALR arrive already sign-extended so the extender passes them.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_known = 1'b1;
    w_imm   = '0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: w_imm = {i_instr[31:12], 12'b0};
      OPC_OPIMM, OPC_LOAD: w_imm = {20'b0, i_instr[31:20]};
      OPC_STORE: w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_JAL: w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      OPC_JALR: w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_BRANCH: w_imm = {19'b0, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
      default: w_known = 1'b0;
    endcase
  end

  assign w_en = i_lane_valid & w_len_ok & w_known;

  always_comb begin
    o_lane            = '0;
    o_lane.op_code    = w_opc;
    o_lane.lane_valid = i_lane_valid;
    o_lane.en         = w_en;
    o_lane.imm_raw    = w_en ? w_imm : 32'h0;
    // Shift-immediates (funct3 001 / 101) carry an unsigned shamt.
    o_lane.ext_type   = w_en & (w_opc == OPC_OPIMM) & (i_instr[13:12] == 2'b01);
    // OP and SYSTEM are legal but need no immediate; a bad length field is
    // always illegal.
    o_lane.illegal    = i_lane_valid & ~w_en &
                        (~w_len_ok | ~((w_opc == OPC_OP) | (w_opc == OPC_SYSTEM)));
  end

endmodule

// File: rtl/dual_imm_decode.sv
// dual_imm_decode: two-lane immediate producer feeding the dual-issue sign
// extender, registered behind a 2-entry (main + skid) valid/ready stage.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous kill of the buffered packets
//   in_valid/in_ready   - fetch-side handshake (in_ready is registered)
//   in_instr, in_lane_valid - packet of LANES instructions, lane 0 oldest
//   out_valid/out_ready - downstream handshake
//   imm_raw, op_code, sign_extender_en, sign_extender_type,
//   out_lane_valid, illegal - per-lane registered decode results
module dual_imm_decode
  import dual_imm_decode_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*32-1:0] in_instr,
  input  logic [LANES-1:0]   in_lane_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*32-1:0] imm_raw,
  output logic [LANES*5-1:0] op_code,
  output logic [LANES-1:0]   sign_extender_en,
  output logic [LANES-1:0]   sign_extender_type,
  output logic [LANES-1:0]   out_lane_valid,
  output logic [LANES-1:0]   illegal
);

  imm_lane_t [LANES-1:0] w_fmt;
  imm_lane_t [LANES-1:0] r_main;
  imm_lane_t [LANES-1:0] r_skid;
  buf_state_e            r_state;
  logic                  w_accept;
  logic                  w_pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imm_lane_format u_fmt (
      .i_instr     (in_instr[g*32 +: 32]),
      .i_lane_valid(in_lane_valid[g]),
      .o_lane      (w_fmt[g])
    );

    assign imm_raw[g*32 +: 32]   = r_main[g].imm_raw;
    assign op_code[g*5 +: 5]     = r_main[g].op_code;
    assign sign_extender_en[g]   = r_main[g].en;
    assign sign_extender_type[g] = r_main[g].ext_type;
    assign out_lane_valid[g]     = r_main[g].lane_valid;
    assign illegal[g]            = r_main[g].illegal;
  end

  // Both handshake outputs decode the state register only, so in_ready has
  // no combinational path from out_ready.
  assign in_ready  = (r_state != BUF_TWO);
  assign out_valid = (r_state != BUF_EMPTY);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  // NOTE: the payload registers are reset too, because the outputs must read
  // zero during reset; a plain pipeline payload would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= BUF_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      case (r_state)
        BUF_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_fmt;
            r_state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (w_accept && w_pop) begin
            r_main <= w_fmt;
          end else if (w_accept) begin
            r_skid  <= w_fmt;
            r_state <= BUF_TWO;
          end else if (w_pop) begin
            r_state <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (w_pop) begin
            r_main  <= r_skid;
            r_state <= BUF_ONE;
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_imm_decode.sv
// Directed self-checking bench for dual_imm_decode. Inputs change on the
// falling edge; outputs are observed on the following falling edge.
module tb_dual_imm_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_instr = '0;
  logic [1:0]  in_lane_valid = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] imm_raw;
  logic [9:0]  op_code;
  logic [1:0]  sign_extender_en;
  logic [1:0]  sign_extender_type;
  logic [1:0]  out_lane_valid;
  logic [1:0]  illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_imm_decode #(.LANES(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_lane_valid     (in_lane_valid),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .imm_raw           (imm_raw),
    .op_code           (op_code),
    .sign_extender_en  (sign_extender_en),
    .sign_extender_type(sign_extender_type),
    .out_lane_valid    (out_lane_valid),
    .illegal           (illegal)
  );

  // {imm_raw, op_code, en, type, lane_valid, illegal} for one lane
  function automatic logic [40:0] lane_obs(input int l);
    return {imm_raw[l*32 +: 32], op_code[l*5 +: 5], sign_extender_en[l],
            sign_extender_type[l], out_lane_valid[l], illegal[l]};
  endfunction

  function automatic logic [81:0] all_payload();
    return {imm_raw, op_code, sign_extender_en, sign_extender_type,
            out_lane_valid, illegal};
  endfunction

  // Present one packet with out_ready high; observe after the accepting edge.
  task automatic send_one(input logic [31:0] i1, input logic [31:0] i0,
                          input logic [1:0] lv);
    out_ready     = 1'b1;
    in_instr      = {i1, i0};
    in_lane_valid = lv;
    in_valid      = 1'b1;
    @(negedge clk);
    in_valid      = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_handshake got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    checks++;
    if (all_payload() !== '0) begin
      failures++;
      $display("FAIL reset_payload got=%h exp=0", all_payload());
    end
  endtask

  task automatic test_dual_format();
    send_one(32'h12345037, 32'hFFF00093, 2'b11);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL dual_latency got out_valid=%b exp=1", out_valid);
    end
    checks++;
    if (lane_obs(0) !== {32'h00000FFF, 5'b00100, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL dual_lane0 got=%h exp=%h", lane_obs(0),
               {32'h00000FFF, 5'b00100, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if (lane_obs(1) !== {32'h12345000, 5'b01101, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL dual_lane1 got=%h exp=%h", lane_obs(1),
               {32'h12345000, 5'b01101, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL dual_pop_empty got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_store_branch();
    send_one(32'hFE000CE3, 32'hFE112E23, 2'b11);
    checks++;
    if (lane_obs(0) !== {32'hFFFFFFFC, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL store_lane0 got=%h exp=%h", lane_obs(0),
               {32'hFFFFFFFC, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if (lane_obs(1) !== {32'h00001FF8, 5'b11000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL branch_lane1 got=%h exp=%h", lane_obs(1),
               {32'h00001FF8, 5'b11000, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_shift_empty_lane();
    send_one(32'h12345037, 32'h00509093, 2'b01);
    checks++;
    if (lane_obs(0) !== {32'h00000005, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL shift_lane0 got=%h exp=%h", lane_obs(0),
               {32'h00000005, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    checks++;
    if (lane_obs(1) !== {32'h00000000, 5'b01101, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL empty_lane1 got=%h exp=%h", lane_obs(1),
               {32'h00000000, 5'b01101, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    send_one(32'hFF9FF0EF, 32'h0000007F, 2'b11);
    checks++;
    if (lane_obs(0) !== {32'h00000000, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL illegal_lane0 got=%h exp=%h", lane_obs(0),
               {32'h00000000, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    checks++;
    if (lane_obs(1) !== {32'hFFFFFFF8, 5'b11011, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL jal_lane1 got=%h exp=%h", lane_obs(1),
               {32'hFFFFFFF8, 5'b11011, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] exp_q[3] = '{32'h1, 32'h2, 32'h3};
    logic        acc;
    out_ready     = 1'b0;
    in_lane_valid = 2'b01;
    in_valid      = 1'b1;
    in_instr      = {32'h0, 32'h00100093};  // A: addi imm 1
    @(negedge clk);
    in_instr      = {32'h0, 32'h00200093};  // B: addi imm 2
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_fall got in_ready=%b exp=0", in_ready);
    end
    in_instr      = {32'h0, 32'h00300093};  // C: addi imm 3, must be held
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, imm_raw[31:0]} !== {1'b0, 1'b1, 32'h1}) begin
      failures++;
      $display("FAIL bp_hold got in_ready=%b out_valid=%b imm=%h exp 0/1/00000001",
               in_ready, out_valid, imm_raw[31:0]);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (out_valid && out_ready) got.push_back(imm_raw[31:0]);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() !== 3) begin
      failures++;
      $display("FAIL bp_pop_count got=%0d exp=3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    out_ready     = 1'b0;
    in_lane_valid = 2'b11;
    in_valid      = 1'b1;
    in_instr      = {32'h12345037, 32'hFFF00093};
    @(negedge clk);
    in_instr      = {32'hFE000CE3, 32'hFE112E23};
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL flush_pre_two got out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready);
    end
    flush    = 1'b1;
    in_instr = {32'h00509093, 32'h00509093};
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, lane_obs(0)} !== {1'b0, 1'b1, 41'h0}) begin
      failures++;
      $display("FAIL flush_clear got out_valid=%b in_ready=%b lane0=%h exp 0/1/0",
               out_valid, in_ready, lane_obs(0));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready     = 1'b0;
    in_lane_valid = 2'b11;
    in_valid      = 1'b1;
    in_instr      = {32'hFF9FF0EF, 32'h12345037};
    @(negedge clk);
    in_valid      = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got out_valid=%b exp=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, all_payload()} !== {1'b0, 1'b1, 82'h0}) begin
      failures++;
      $display("FAIL arst_clear got out_valid=%b in_ready=%b payload=%h exp 0/1/0",
               out_valid, in_ready, all_payload());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_dual_format();
    test_store_branch();
    test_shift_empty_lane();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_imm_decode.md
# dual_imm_decode

Two-lane decode-side producer of the immediate interface consumed by the dual-issue sign extender. Each cycle it accepts a fetch packet of up to two 32-bit RV32I instructions and extracts, per lane:
- the 5-bit major opcode,
- the raw immediate, pre-formatted per opcode class,
- the extender enable and the extender type.

Results are registered behind a valid/ready pipeline stage with a skid buffer. The block sits between fetch and the sign-extend/register-read stage.

## Interface
- LANES, 2, instruction lanes per packet (fixed at 2; the parameter is for readability only)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline kill (branch mispredict)
- in_valid  in  1  fetch packet valid
- in_ready  out  1  stage can accept a packet
- in_instr  in  32 x 2  instruction words, lane 0 is older
- in_lane_valid  in  1 x 2  per-lane instruction present
- out_valid  out  1  decoded packet valid
- out_ready  in  1  downstream accepts the packet
- imm_raw  out  32 x 2  formatted immediate, drives the extender `in`
- op_code  out  5 x 2  instr[6:2]
- sign_extender_en  out  1 x 2  per-lane extender enable
- sign_extender_type  out  1 x 2  0 = signed, 1 = unsigned
- out_lane_valid  out  1 x 2  lane carries an instruction
- illegal  out  1 x 2  lane valid, but the opcode is unsupported or instr[1:0] != 2'b11

## Operation
- Per-lane formatting is combinational on in_instr. The opcode class is selected by instr[6:2]:
  - 01101 LUI / 00101 AUIPC: {instr[31:12], 12'b0}.
  - 00100 OP-IMM and 00000 LOAD: {20'b0, instr[31:20]}. The extender performs the extension.
  - 01000 STORE: fully sign-extended S-immediate, {{20{i[31]}}, i[31:25], i[11:7]}. The extender passes it through.
  - 11011 JAL: fully sign-extended 21-bit J-immediate. 11001 JALR: fully sign-extended 12-bit I-immediate.
  - 11000 BRANCH: {19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}. The extender extends this 13-bit value.
- sign_extender_en = 1 only when all of the following hold: the lane is valid, instr[1:0] == 2'b11, and the opcode is one of the eight above.
- When sign_extender_en = 0: imm_raw = 0 and sign_extender_type = 0. op_code is still driven as instr[6:2].
- sign_extender_type = 1 only for OP-IMM with funct3 001 or 101 (shift-immediates). Otherwise it is 0.
- illegal is asserted for a valid lane when sign_extender_en = 0 and the opcode is not 01100 (OP) or 11100 (SYSTEM).
- The output stage is a 2-entry buffer made of a main register and a skid register.
  - States: EMPTY, ONE (main full), TWO (main and skid full).
  - EMPTY, on accept: -> ONE.
  - ONE, accept without pop: -> TWO. Pop without accept: -> EMPTY. Accept and pop together: stays ONE, and main loads the new packet.
  - TWO, on pop: skid moves to main -> ONE. No accept is possible in TWO.
- Accept condition: in_valid & in_ready. Pop condition: out_valid & out_ready.
- in_ready = (state != TWO). It is a registered signal and has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Packet order is strictly preserved.

## Timing
- Latency: an accept in cycle N gives out_valid in cycle N+1.
- Throughput: one packet per cycle while out_ready = 1.
- Reset (asynchronous, rst_n low): state = EMPTY, in_ready = 1, out_valid = 0. All payload outputs are 0, including imm_raw, op_code, en, type, out_lane_valid and illegal.
- Reset asserted mid-operation: both entries are dropped immediately. There is no partial-packet output.
- flush: on the next edge, state = EMPTY and in_ready = 1. Any packet presented together with flush is discarded, and flush takes priority over accept. Payload registers are cleared to 0.
- Outputs hold stable while out_valid = 1 and out_ready = 0.

## Structure
- Shared package:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_OP, OPC_SYSTEM);
  - typedef imm_lane_t as a struct {imm_raw, op_code, en, type, lane_valid, illegal};
  - enum buf_state_e for EMPTY / ONE / TWO.
- Sub-module imm_lane_format: purely combinational single-lane formatter, instantiated twice.
- The top level holds the buffer FSM and the registers.

## Test plan
- Dual-lane formatting: lane 0 = 0xFFF00093 (addi x1,x0,-1) and lane 1 = 0x12345037 (lui). Required: lane 0 imm_raw 0x00000FFF, op 00100, en 1, type 0. Lane 1 imm_raw 0x12345000, op 01101.
- Store and branch: lane 0 = 0xFE112E23 (sw x1,-4(x2)) and lane 1 = 0xFE000CE3 (beq x0,x0,-8). Required: lane 0 imm_raw 0xFFFFFFFC, op 01000. Lane 1 imm_raw 0x00001FF8, op 11000.
- Shift and empty lane: lane 0 = 0x00509093 (slli x1,x1,5) and in_lane_valid[1] = 0. Required: lane 0 imm_raw 0x00000005, type 1. Lane 1 en 0, imm_raw 0, illegal 0.
- Backpressure: hold out_ready = 0 while pushing packets A, B and C. Required: in_ready falls the cycle after B is accepted, and C is held at the input. Raising out_ready then pops A, B, C in order, with no loss and no duplication.
- Flush and reset: flush while in TWO. Required: next cycle out_valid 0 and in_ready 1. Asserting rst_n low mid-stream immediately zeroes all outputs.
- Illegal opcode: lane 0 = 0x0000007F. Required: illegal 1, en 0, imm_raw 0.
